// File: rtl/mini6502_sys.sv
// mini6502_sys: 6502-subset CPU with internal 4 KB ROM (0xF000-0xFFFF) and 256 B RAM (0x0000-0x00FF).
// Optional macro DECIMAL_EN enables packed-BCD ADC/SBC when the D flag is set.

module mini6502_mem #(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 8
) (
    input  logic        clk,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata
);
    logic [7:0] ROM [0:(1<<ROM_AW)-1];
    logic [7:0] RAM [0:(1<<RAM_AW)-1];
    logic       rom_sel;
    logic       ram_sel;

    assign rom_sel = &addr[15:ROM_AW];
    assign ram_sel = (addr[15:RAM_AW] == '0);

    always_comb begin
        rdata = '0;
        if (rom_sel)
            rdata = ROM[addr[ROM_AW-1:0]];
        else if (ram_sel)
            rdata = RAM[addr[RAM_AW-1:0]];
    end

    // A store into the ROM window writes back the byte already there, so ROM content never changes.
    always_ff @(posedge clk) begin
        if (we && ram_sel)
            RAM[addr[RAM_AW-1:0]] <= wdata;
        else if (we && rom_sel)
            ROM[addr[ROM_AW-1:0]] <= ROM[addr[ROM_AW-1:0]];
    end
endmodule

module mini6502_sys #(
    parameter int ROM_AW = 12,
    parameter int RAM_AW = 8
) (
    input  logic        ph1,
    input  logic        resetb,
    output logic [15:0] dbg_pc,
    output logic [7:0]  dbg_a,
    output logic [7:0]  dbg_p
);
    localparam logic [7:0] LDA_IMM = 8'hA9, LDA_ZP = 8'hA5, STA_ZP = 8'h85, LDX_IMM = 8'hA2;
    localparam logic [7:0] ADC_IMM = 8'h69, ADC_ZP = 8'h65, SBC_IMM = 8'hE9, SBC_ZP = 8'hE5;
    localparam logic [7:0] TAX = 8'hAA, TXA = 8'h8A, INX = 8'hE8, DEX = 8'hCA;
    localparam logic [7:0] CLC = 8'h18, SEC = 8'h38, CLD = 8'hD8, SED = 8'hF8, CLV = 8'hB8;
    localparam logic [7:0] JMP_ABS = 8'h4C;
    localparam logic [7:0] BEQ = 8'hF0, BNE = 8'hD0, BCC = 8'h90, BCS = 8'hB0, BMI = 8'h30, BPL = 8'h10;

    typedef enum logic [2:0] {RST0, RST1, FETCH, OP1, OP2, EXEC} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  p;
    logic [7:0]  opcode;
    logic [7:0]  operand;

    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        we;
    logic        is_zp;
    logic        taken;
    logic [7:0]  x_inc;
    logic [7:0]  x_dec;

    logic        is_sbc;
    logic [7:0]  alu_m;
    logic [8:0]  sum;
    logic [7:0]  alu_a;
    logic        alu_c;
    logic        alu_v;
    logic        alu_n;
    logic        alu_z;
`ifdef DECIMAL_EN
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic        lo_c;
`endif

    mini6502_mem #(
        .ROM_AW(ROM_AW),
        .RAM_AW(RAM_AW)
    ) mem (
        .clk  (ph1),
        .addr (addr),
        .wdata(a),
        .we   (we),
        .rdata(rdata)
    );

    assign is_zp = (opcode == LDA_ZP) || (opcode == ADC_ZP) ||
                   (opcode == SBC_ZP) || (opcode == STA_ZP);
    assign we    = (state == OP2) && (opcode == STA_ZP);
    assign x_inc = x + 8'd1;
    assign x_dec = x - 8'd1;

    always_comb begin
        addr = pc;
        case (state)
            RST0:    addr = 16'hFFFC;
            RST1:    addr = 16'hFFFD;
            OP2:     addr = is_zp ? {8'h00, operand} : pc;
            default: addr = pc;
        endcase
    end

    always_comb begin
        case (opcode)
            BEQ:     taken = p[1];
            BNE:     taken = ~p[1];
            BCC:     taken = ~p[0];
            BCS:     taken = p[0];
            BMI:     taken = p[7];
            BPL:     taken = ~p[7];
            default: taken = 1'b0;
        endcase
    end

    // The operand byte is on rdata in OP1 (immediate) and OP2 (zero page) alike.
    always_comb begin
        is_sbc = (opcode == SBC_IMM) || (opcode == SBC_ZP);
        alu_m  = is_sbc ? ~rdata : rdata;
        sum    = {1'b0, a} + {1'b0, alu_m} + {8'b0, p[0]};
        alu_a  = sum[7:0];
        alu_c  = sum[8];
        alu_v  = (a[7] == alu_m[7]) && (sum[7] != a[7]);
        alu_n  = sum[7];
        alu_z  = (sum[7:0] == 8'h00);
`ifdef DECIMAL_EN
        lo   = '0;
        hi   = '0;
        lo_c = 1'b0;
        if (p[3]) begin
            if (!is_sbc) begin
                lo   = {1'b0, a[3:0]} + {1'b0, rdata[3:0]} + {4'b0, p[0]};
                lo_c = (lo > 5'd9);
                if (lo_c)
                    lo = lo + 5'd6;
                hi    = {1'b0, a[7:4]} + {1'b0, rdata[7:4]} + {4'b0, lo_c};
                alu_c = (hi > 5'd9);
                if (alu_c)
                    hi = hi + 5'd6;
            end else begin
                lo   = {1'b0, a[3:0]} - {1'b0, rdata[3:0]} - {4'b0, ~p[0]};
                lo_c = lo[4];
                if (lo_c)
                    lo = lo - 5'd6;
                hi    = {1'b0, a[7:4]} - {1'b0, rdata[7:4]} - {4'b0, lo_c};
                alu_c = ~hi[4];
                if (hi[4])
                    hi = hi - 5'd6;
            end
            alu_a = {hi[3:0], lo[3:0]};
        end
`endif
    end

    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            state   <= RST0;
            pc      <= '0;
            a       <= '0;
            x       <= '0;
            p       <= 8'h20;
            opcode  <= '0;
            operand <= '0;
        end else begin
            case (state)
                RST0: begin
                    pc[7:0] <= rdata;
                    state   <= RST1;
                end
                RST1: begin
                    pc[15:8] <= rdata;
                    state    <= FETCH;
                end
                FETCH: begin
                    opcode <= rdata;
                    pc     <= pc + 16'd1;
                    case (rdata)
                        LDA_IMM, LDX_IMM, ADC_IMM, SBC_IMM,
                        LDA_ZP, ADC_ZP, SBC_ZP, STA_ZP, JMP_ABS,
                        BEQ, BNE, BCC, BCS, BMI, BPL: state <= OP1;
                        default:                      state <= EXEC;
                    endcase
                end
                OP1: begin
                    operand <= rdata;
                    pc      <= pc + 16'd1;
                    state   <= FETCH;
                    case (opcode)
                        LDA_IMM: begin
                            a    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                        end
                        LDX_IMM: begin
                            x    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                        end
                        ADC_IMM, SBC_IMM: begin
                            a    <= alu_a;
                            p[7] <= alu_n;
                            p[6] <= alu_v;
                            p[1] <= alu_z;
                            p[0] <= alu_c;
                        end
                        LDA_ZP, ADC_ZP, SBC_ZP, STA_ZP, JMP_ABS: state <= OP2;
                        BEQ, BNE, BCC, BCS, BMI, BPL: begin
                            if (taken)
                                state <= EXEC;
                        end
                        default: ;
                    endcase
                end
                OP2: begin
                    state <= FETCH;
                    case (opcode)
                        LDA_ZP: begin
                            a    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                        end
                        ADC_ZP, SBC_ZP: begin
                            a    <= alu_a;
                            p[7] <= alu_n;
                            p[6] <= alu_v;
                            p[1] <= alu_z;
                            p[0] <= alu_c;
                        end
                        JMP_ABS: pc <= {rdata, operand};
                        default: ;
                    endcase
                end
                EXEC: begin
                    state <= FETCH;
                    case (opcode)
                        TAX: begin
                            x    <= a;
                            p[7] <= a[7];
                            p[1] <= (a == 8'h00);
                        end
                        TXA: begin
                            a    <= x;
                            p[7] <= x[7];
                            p[1] <= (x == 8'h00);
                        end
                        INX: begin
                            x    <= x_inc;
                            p[7] <= x_inc[7];
                            p[1] <= (x_inc == 8'h00);
                        end
                        DEX: begin
                            x    <= x_dec;
                            p[7] <= x_dec[7];
                            p[1] <= (x_dec == 8'h00);
                        end
                        CLC: p[0] <= 1'b0;
                        SEC: p[0] <= 1'b1;
                        CLD: p[3] <= 1'b0;
                        SED: p[3] <= 1'b1;
                        CLV: p[6] <= 1'b0;
                        // Only taken branches reach EXEC; PC already points past the offset byte.
                        BEQ, BNE, BCC, BCS, BMI, BPL: pc <= pc + {{8{operand[7]}}, operand};
                        default: ;
                    endcase
                end
                default: state <= RST0;
            endcase
        end
    end

    assign dbg_pc = pc;
    assign dbg_a  = a;
    assign dbg_p  = p;
endmodule

// File: tb/tb_mini6502_sys.sv
// Directed bench for mini6502_sys: preloads a program into mem.ROM and checks registers and mem.RAM.
// Expected values follow the DECIMAL_EN setting of the build.

module tb_mini6502_sys;
    logic        ph1 = 1'b0;
    logic        resetb;
    logic [15:0] dbg_pc;
    logic [7:0]  dbg_a;
    logic [7:0]  dbg_p;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc;
    int dex_seen;
    logic [15:0] prev_pc;

`ifdef DECIMAL_EN
    localparam logic [15:0] EXP_A_ADD  = 16'h0004;
    localparam logic [15:0] EXP_P_ADD  = 16'h00E9;
    localparam logic [15:0] EXP_P_LOOP = 16'h0063;
    localparam logic [15:0] EXP_P_CLV  = 16'h0023;
    localparam logic [15:0] EXP_P_END  = 16'h00A1;
`else
    localparam logic [15:0] EXP_A_ADD  = 16'h009E;
    localparam logic [15:0] EXP_P_ADD  = 16'h00E8;
    localparam logic [15:0] EXP_P_LOOP = 16'h0062;
    localparam logic [15:0] EXP_P_CLV  = 16'h0022;
    localparam logic [15:0] EXP_P_END  = 16'h00A0;
`endif

    logic [7:0] prog [$] = '{
        8'h18,                      // F000 CLC
        8'hA9, 8'h50,               // F001 LDA #50
        8'h69, 8'h50,               // F003 ADC #50
        8'h38,                      // F005 SEC
        8'hA9, 8'h50,               // F006 LDA #50
        8'hE9, 8'hF0,               // F008 SBC #F0
        8'hE9, 8'h60,               // F00A SBC #60
        8'h85, 8'h30,               // F00C STA 30
        8'hA9, 8'h9D,               // F00E LDA #9D
        8'h85, 8'h30,               // F010 STA 30
        8'hA9, 8'h00,               // F012 LDA #00
        8'h18,                      // F014 CLC
        8'h65, 8'h30,               // F015 ADC 30
        8'hF8,                      // F017 SED
        8'h18,                      // F018 CLC
        8'hA9, 8'h58,               // F019 LDA #58
        8'h69, 8'h46,               // F01B ADC #46
        8'hD8,                      // F01D CLD
        8'hA2, 8'h03,               // F01E LDX #3
        8'hCA,                      // F020 DEX
        8'hD0, 8'hFD,               // F021 BNE F020
        8'h8A,                      // F023 TXA
        8'hE8,                      // F024 INX
        8'hAA,                      // F025 TAX
        8'hF0, 8'h02,               // F026 BEQ F02A
        8'hA9, 8'h77,               // F028 LDA #77 (skipped)
        8'hB8,                      // F02A CLV
        8'h02,                      // F02B undefined opcode
        8'hA9, 8'hC3,               // F02C LDA #C3
        8'h4C, 8'h2E, 8'hF0         // F02E JMP F02E
    };

    mini6502_sys #(
        .ROM_AW(12),
        .RAM_AW(8)
    ) dut (
        .ph1   (ph1),
        .resetb(resetb),
        .dbg_pc(dbg_pc),
        .dbg_a (dbg_a),
        .dbg_p (dbg_p)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_to(input string tag, input logic [15:0] target);
        for (int i = 0; i < 200 && dbg_pc !== target; i++)
            @(negedge ph1);
        check(tag, dbg_pc, target);
    endtask

    task automatic put(input int idx, input logic [7:0] val);
        dut.mem.ROM[idx] <= val;
    endtask

    initial begin
        resetb = 1'b1;
        foreach (prog[i])
            put(i, prog[i]);
        put(4092, 8'h00);
        put(4093, 8'hF0);
        #2 resetb = 1'b0;

        @(negedge ph1);
        check("reset_pc", dbg_pc, 16'h0000);
        check("reset_a", {8'h00, dbg_a}, 16'h0000);
        check("reset_p", {8'h00, dbg_p}, 16'h0020);
        resetb = 1'b1;

        @(negedge ph1);
        check("rst0_pc", dbg_pc, 16'h0000);
        @(negedge ph1);
        check("rst1_pc", dbg_pc, 16'hF000);
        @(negedge ph1);
        check("first_fetch_pc", dbg_pc, 16'hF001);

        run_to("reach_F006", 16'hF006);
        check("adc_bin_a", {8'h00, dbg_a}, 16'h00A0);
        check("adc_bin_p", {8'h00, dbg_p}, 16'h00E0);

        run_to("reach_F00B", 16'hF00B);
        check("sbc_f0_a", {8'h00, dbg_a}, 16'h0060);
        check("sbc_f0_p", {8'h00, dbg_p}, 16'h0020);

        run_to("reach_F00D", 16'hF00D);
        check("sbc_60_a", {8'h00, dbg_a}, 16'h00FF);
        check("sbc_60_p", {8'h00, dbg_p}, 16'h00A0);

        run_to("sta_op1", 16'hF012);
        check("ram_before_store", {8'h00, dut.mem.RAM[48]}, 16'h00FF);
        @(negedge ph1);
        check("ram_after_store", {8'h00, dut.mem.RAM[48]}, 16'h009D);
        check("sta_pc_hold", dbg_pc, 16'hF012);

        run_to("reach_F018", 16'hF018);
        check("adc_zp_a", {8'h00, dbg_a}, 16'h009D);
        check("adc_zp_p", {8'h00, dbg_p}, 16'h00A0);

        run_to("reach_F01E", 16'hF01E);
        check("adc_dec_a", {8'h00, dbg_a}, EXP_A_ADD);
        check("adc_dec_p", {8'h00, dbg_p}, EXP_P_ADD);

        run_to("ldx_fetch", 16'hF01F);
        cyc      = 0;
        dex_seen = 0;
        prev_pc  = dbg_pc;
        while (dbg_pc !== 16'hF024 && cyc < 100) begin
            @(negedge ph1);
            cyc++;
            if (dbg_pc === 16'hF021 && prev_pc !== 16'hF021)
                dex_seen++;
            prev_pc = dbg_pc;
        end
        check("loop_cycles", 16'(cyc), 16'd16);
        check("dex_count", 16'(dex_seen), 16'd3);
        check("loop_p", {8'h00, dbg_p}, EXP_P_LOOP);
        check("loop_a", {8'h00, dbg_a}, EXP_A_ADD);

        run_to("reach_F02B", 16'hF02B);
        check("beq_skip_a", {8'h00, dbg_a}, 16'h0000);
        check("tax_p", {8'h00, dbg_p}, EXP_P_LOOP);

        run_to("reach_F02D", 16'hF02D);
        check("clv_p", {8'h00, dbg_p}, EXP_P_CLV);

        run_to("reach_F02F", 16'hF02F);
        check("final_a", {8'h00, dbg_a}, 16'h00C3);
        check("final_p", {8'h00, dbg_p}, EXP_P_END);

        @(negedge ph1);
        check("jmp_op1_pc", dbg_pc, 16'hF030);
        @(negedge ph1);
        check("jmp_target_pc", dbg_pc, 16'hF02E);
        @(negedge ph1);
        check("jmp_refetch_pc", dbg_pc, 16'hF02F);

        #3 resetb = 1'b0;
        #1;
        check("async_reset_pc", dbg_pc, 16'h0000);
        check("async_reset_a", {8'h00, dbg_a}, 16'h0000);
        check("async_reset_p", {8'h00, dbg_p}, 16'h0020);
        check("ram_kept", {8'h00, dut.mem.RAM[48]}, 16'h009D);

        @(negedge ph1);
        resetb = 1'b1;
        repeat (3) @(negedge ph1);
        check("restart_fetch_pc", dbg_pc, 16'hF001);
        run_to("restart_F006", 16'hF006);
        check("restart_adc_a", {8'h00, dbg_a}, 16'h00A0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
